change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 23 ++
 rtl/change_dispenser.sv | 119 +++++++++++
 tb/tb_change_dispenser.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake between the upstream vending FSM, the coin hopper and the change dispenser.
interface change_dispenser_if;
  logic       d;
  logic [2:0] r;
  logic       hopper_empty;
  logic       motor_on;
  logic       coin_out;
  logic       busy;
  logic       done;
  logic       hopper_fault;
  logic       err;
  logic       overrun;

  modport master (
    output d, r, hopper_empty,
    input  motor_on, coin_out, busy, done, hopper_fault, err, overrun
  );

  modport slave (
    input  d, r, hopper_empty,
    output motor_on, coin_out, busy, done, hopper_fault, err, overrun
  );
endinterface

// File: rtl/change_dispenser.sv
// Drink vend + coin refund sequencer: drives the motor, then ejects min(r,4) coins
// spaced by COIN_GAP idle cycles, stalling while the hopper is empty.
module change_dispenser #(
  parameter int unsigned MOTOR_CYCLES = 4,
  parameter int unsigned COIN_GAP     = 2
) (
  input logic          clk,
  input logic          reset,
  change_dispenser_if.slave bus
);

  localparam int unsigned MOTOR_W  = (MOTOR_CYCLES > 2) ? $clog2(MOTOR_CYCLES) : 1;
  localparam int unsigned GAP_W    = (COIN_GAP > 2) ? $clog2(COIN_GAP) : 1;
  localparam int unsigned REFUND_W = 3;
  localparam logic [REFUND_W-1:0] MAX_REFUND = REFUND_W'(4);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VEND = 3'd1,
    PAY  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [MOTOR_W-1:0]    motor_cnt, motor_cnt_n;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
  logic [REFUND_W-1:0]   refund_cnt, refund_cnt_n;
  logic                  err_q, err_n;
  logic                  overrun_q, overrun_n;
  logic                  motor_on_q, busy_q, done_q;

  // State, counters, sticky flags; Moore outputs are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      motor_cnt  <= '0;
      gap_cnt    <= '0;
      refund_cnt <= '0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      motor_on_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      motor_cnt  <= motor_cnt_n;
      gap_cnt    <= gap_cnt_n;
      refund_cnt <= refund_cnt_n;
      err_q      <= err_n;
      overrun_q  <= overrun_n;
      motor_on_q <= (state_n == VEND);
      busy_q     <= (state_n != IDLE);
      done_q     <= (state_n == DONE);
    end
  end

  // Next-state and counter update
  always_comb begin
    state_n      = state;
    motor_cnt_n  = motor_cnt;
    gap_cnt_n    = gap_cnt;
    refund_cnt_n = refund_cnt;
    err_n        = err_q;
    overrun_n    = overrun_q;

    if ((state != IDLE) && bus.d) begin
      overrun_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (bus.d) begin
          state_n      = VEND;
          motor_cnt_n  = MOTOR_W'(MOTOR_CYCLES - 1);
          refund_cnt_n = (bus.r > MAX_REFUND) ? MAX_REFUND : bus.r;
          err_n        = err_q | (bus.r > MAX_REFUND);
        end
      end
      VEND: begin
        if (motor_cnt == '0) begin
          state_n = (refund_cnt == '0) ? DONE : PAY;
        end else begin
          motor_cnt_n = motor_cnt - MOTOR_W'(1);
        end
      end
      PAY: begin
        // An empty hopper holds the refund in place until coins arrive
        if (!bus.hopper_empty && (refund_cnt != '0)) begin
          refund_cnt_n = refund_cnt - REFUND_W'(1);
          gap_cnt_n    = GAP_W'(COIN_GAP - 1);
          state_n      = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = (refund_cnt == '0) ? DONE : PAY;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.motor_on     = motor_on_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.overrun      = overrun_q;
  assign bus.coin_out     = (state == PAY) && !bus.hopper_empty;
  assign bus.hopper_fault = (state == PAY) && bus.hopper_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a per-transaction timeline model.
module tb_change_dispenser;

  localparam int unsigned M = 4;
  localparam int unsigned G = 2;
  localparam int WIN = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic err_m;
  logic ovr_m;

  change_dispenser_if bus ();

  change_dispenser #(.MOTOR_CYCLES(M), .COIN_GAP(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and compare a 64-cycle window of outputs to the timeline model.
  // extra_at: -1 none, -2 random cycle inside the busy window, >=0 fixed cycle.
  task automatic run_txn(input string name, input logic [2:0] rv,
                         input logic [63:0] sched, input int extra_at);
    logic [63:0] e_mot, e_coin, e_done, e_flt, e_busy;
    logic [63:0] o_mot, o_coin, o_done, o_flt, o_busy;
    int n, pos, done_c, xa;
    e_mot = '0; e_coin = '0; e_done = '0; e_flt = '0; e_busy = '0;
    o_mot = '0; o_coin = '0; o_done = '0; o_flt = '0; o_busy = '0;
    n = (rv > 3'd4) ? 4 : int'(rv);
    for (int c = 0; c < int'(M); c++) e_mot[c] = 1'b1;
    pos = int'(M);
    for (int k = 0; k < n; k++) begin
      while (pos < WIN && sched[pos]) begin
        e_flt[pos] = 1'b1;
        pos++;
      end
      e_coin[pos] = 1'b1;
      pos += 1 + int'(G);
    end
    done_c = pos;
    e_done[done_c] = 1'b1;
    for (int c = 0; c <= done_c; c++) e_busy[c] = 1'b1;
    xa = (extra_at == -2) ? int'($urandom_range(0, done_c)) : extra_at;
    if (rv > 3'd4) err_m = 1'b1;
    if (xa >= 0) ovr_m = 1'b1;

    @(posedge clk); #1;
    bus.d = 1'b1; bus.r = rv; bus.hopper_empty = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      @(posedge clk); #1;
      bus.d = (c == xa);
      bus.r = 3'($urandom);
      bus.hopper_empty = sched[c];
      @(negedge clk);
      o_mot[c]  = bus.motor_on;
      o_coin[c] = bus.coin_out;
      o_done[c] = bus.done;
      o_flt[c]  = bus.hopper_fault;
      o_busy[c] = bus.busy;
    end
    bus.d = 1'b0;

    n_checks++; if (o_mot !== e_mot) $display("FAIL %s motor_on got %h exp %h", name, o_mot, e_mot); else n_pass++;
    n_checks++; if (o_coin !== e_coin) $display("FAIL %s coin_out got %h exp %h", name, o_coin, e_coin); else n_pass++;
    n_checks++; if (o_done !== e_done) $display("FAIL %s done got %h exp %h", name, o_done, e_done); else n_pass++;
    n_checks++; if (o_flt !== e_flt) $display("FAIL %s hopper_fault got %h exp %h", name, o_flt, e_flt); else n_pass++;
    n_checks++; if (o_busy !== e_busy) $display("FAIL %s busy got %h exp %h", name, o_busy, e_busy); else n_pass++;
    n_checks++; if (bus.err !== err_m) $display("FAIL %s err got %b exp %b", name, bus.err, err_m); else n_pass++;
    n_checks++; if (bus.overrun !== ovr_m) $display("FAIL %s overrun got %b exp %b", name, bus.overrun, ovr_m); else n_pass++;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    bus.d = 1'b0; bus.r = 3'd0; bus.hopper_empty = 1'b0;
    reset = 1'b1;
    err_m = 1'b0; ovr_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = {bus.motor_on, bus.coin_out, bus.busy, bus.done, bus.hopper_fault, bus.err, bus.overrun};
    n_checks++; if (o !== 7'b0) $display("FAIL reset_values got %b exp %b", o, 7'b0); else n_pass++;
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_refund();
    run_txn("no_refund", 3'd0, 64'd0, -1);
  endtask

  task automatic test_refund_spacing();
    run_txn("refund_3", 3'd3, 64'd0, -1);
  endtask

  task automatic test_over_limit();
    run_txn("refund_6", 3'd6, 64'd0, -1);
    run_txn("refund_7", 3'd7, 64'd0, -1);
  endtask

  task automatic test_hopper_stall();
    logic [63:0] s;
    s = '0;
    for (int c = int'(M); c < int'(M) + 5; c++) s[c] = 1'b1;
    run_txn("hopper_stall", 3'd2, s, -1);
  endtask

  task automatic test_overrun();
    run_txn("overrun_vend", 3'd4, 64'd0, 1);
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    logic [2:0] after;
    after = '0;
    @(posedge clk); #1;
    bus.d = 1'b1; bus.r = 3'd3; bus.hopper_empty = 1'b0;
    for (int c = 0; c <= int'(M) + 1; c++) begin
      @(posedge clk); #1;
      bus.d = 1'b0;
    end
    // now in the first GAP cycle after the first coin
    #2 reset = 1'b1;
    #1;
    o = {bus.motor_on, bus.coin_out, bus.busy, bus.done, bus.hopper_fault, bus.err, bus.overrun};
    n_checks++; if (o !== 7'b0) $display("FAIL reset_mid_outputs got %b exp %b", o, 7'b0); else n_pass++;
    err_m = 1'b0; ovr_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      after = after | {bus.coin_out, bus.done, bus.busy};
    end
    n_checks++; if (after !== 3'b0) $display("FAIL reset_mid_quiet got %b exp %b", after, 3'b0); else n_pass++;
    run_txn("after_reset_r1", 3'd1, 64'd0, -1);
  endtask

  task automatic test_random();
    logic [63:0] s;
    int xa;
    for (int t = 0; t < 24; t++) begin
      s = {$urandom, $urandom} & {$urandom, $urandom};
      s[63:40] = '0;
      xa = ($urandom_range(0, 2) == 0) ? -2 : -1;
      run_txn("random", 3'($urandom), s, xa);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    test_reset();
    test_no_refund();
    test_refund_spacing();
    test_over_limit();
    test_hopper_stall();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
